// File: rtl/lcd_text_pkg.sv
// Shared constants, state encoding and reset screen image for the LCD text buffer.
// Pure definitions: no logic, no latency, no flow control.
package lcd_text_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   localparam int LBL_IN_POS  = 0;
   localparam int LBL_OUT_POS = 16;
   localparam int FIELD_A     = 4;
   localparam int FIELD_B     = 20;
   localparam int CELLS       = 32;

   localparam int ITERS  = 16;
   localparam int DIGITS = 5;
   localparam int BCD_W  = 4 * DIGITS;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_CONV_A  = 3'd1;
   localparam state_t S_WRITE_A = 3'd2;
   localparam state_t S_CONV_B  = 3'd3;
   localparam state_t S_WRITE_B = 3'd4;

   // Screen contents straight out of reset: labels, "+00000" in both fields.
   function automatic logic [7:0] init_char(int idx);
      logic [7:0] c;
      c = ASCII_SPACE;
      case (idx)
         LBL_IN_POS:      c = 8'h49;
         LBL_IN_POS + 1:  c = 8'h4E;
         LBL_OUT_POS:     c = 8'h4F;
         LBL_OUT_POS + 1: c = 8'h55;
         LBL_OUT_POS + 2: c = 8'h54;
         FIELD_A, FIELD_B: c = ASCII_PLUS;
         default: begin
            if ((idx > FIELD_A && idx <= FIELD_A + DIGITS) ||
                (idx > FIELD_B && idx <= FIELD_B + DIGITS))
               c = ASCII_ZERO;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: unsigned binary to 5-digit BCD, busy for exactly WIDTH cycles.
// start must only be pulsed while idle; done pulses once with bcd valid and held afterwards.
module bin2bcd_seq
   import lcd_text_pkg::*;
#(
   parameter int WIDTH = ITERS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic [BCD_W-1:0] bcd,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [BCD_W-1:0] bcd_r, adj, nxt_bcd;
   logic [WIDTH-1:0] sh_r, nxt_sh;
   logic [CNT_W-1:0] cnt;
   logic             run;

   always_comb begin
      adj = bcd_r;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      {nxt_bcd, nxt_sh} = {adj, sh_r} << 1;
   end

   // The first iteration on an all-zero BCD register is a bare shift, so it is
   // folded into the start cycle; the remaining WIDTH-1 run while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_r <= '0;
         sh_r  <= '0;
         cnt   <= '0;
         run   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            bcd_r <= {{(BCD_W-1){1'b0}}, bin[WIDTH-1]};
            sh_r  <= {bin[WIDTH-2:0], 1'b0};
            cnt   <= CNT_W'(WIDTH - 1);
            run   <= 1'b1;
         end else if (run) begin
            bcd_r <= nxt_bcd;
            sh_r  <= nxt_sh;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign bcd = bcd_r;

endmodule

// File: rtl/lcd_text_buffer.sv
// 32-cell ASCII screen image; converts two signed values to sign+5 digits on load, 34 cycles busy.
// word is combinational from position; load is dropped while busy, done pulses when both lines land.
module lcd_text_buffer
   import lcd_text_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             iCLK_50MHZ,
   input  logic             iRST_N,
   input  logic             load,
   input  logic [WIDTH-1:0] val_in,
   input  logic [WIDTH-1:0] val_out,
   input  logic [4:0]       position,
   output logic [7:0]       word,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic             sign_a, sign_b;
   logic [WIDTH-1:0] mag_in, mag_out, mag_b;
   logic             accept, conv_start, conv_done;
   logic [WIDTH-1:0] conv_bin;
   logic [BCD_W-1:0] conv_bcd;
   logic [7:0]       scr [CELLS];
   logic             wr_en, wr_sign;
   logic [4:0]       wr_base;

   assign mag_in  = val_in[WIDTH-1]  ? (~val_in  + WIDTH'(1)) : val_in;
   assign mag_out = val_out[WIDTH-1] ? (~val_out + WIDTH'(1)) : val_out;

   // Line 1 converts straight off the input bus in the load cycle; line 2 uses the held copy.
   assign accept     = (state == S_IDLE) && load;
   assign conv_start = accept || (state == S_WRITE_A);
   assign conv_bin   = accept ? mag_in : mag_b;

   bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
      .clk   (iCLK_50MHZ),
      .rst_n (iRST_N),
      .start (conv_start),
      .bin   (conv_bin),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
      if (!iRST_N) begin
         state  <= S_IDLE;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_b  <= '0;
         done   <= 1'b0;
      end else begin
         done <= (state == S_WRITE_B);
         case (state)
            S_IDLE: begin
               if (load) begin
                  sign_a <= val_in[WIDTH-1];
                  sign_b <= val_out[WIDTH-1];
                  mag_b  <= mag_out;
                  state  <= S_CONV_A;
               end
            end
            S_CONV_A:  if (conv_done) state <= S_WRITE_A;
            S_WRITE_A: state <= S_CONV_B;
            S_CONV_B:  if (conv_done) state <= S_WRITE_B;
            S_WRITE_B: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   assign busy    = (state != S_IDLE);
   assign wr_en   = (state == S_WRITE_A) || (state == S_WRITE_B);
   assign wr_base = (state == S_WRITE_A) ? 5'(FIELD_A) : 5'(FIELD_B);
   assign wr_sign = (state == S_WRITE_A) ? sign_a : sign_b;

   always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < CELLS; i++)
            scr[i] <= init_char(i);
      end else if (wr_en) begin
         scr[wr_base] <= wr_sign ? ASCII_MINUS : ASCII_PLUS;
         for (int k = 0; k < DIGITS; k++)
            scr[wr_base + 5'(1 + k)] <= ASCII_ZERO | {4'h0, conv_bcd[4*(DIGITS-1-k) +: 4]};
      end
   end

   assign word = scr[position];

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: table vectors, randomized values against a text-level model,
// plus ignored-load, mid-conversion reset and back-to-back sequences.
`timescale 1ns/100ps
module tb_lcd_text_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] val_in, val_out;
   logic [4:0]  position;
   logic [7:0]  word;
   logic        busy, done;

   int checks   = 0;
   int failures = 0;

   logic [47:0] cur_a, cur_b;
   logic [31:0] lab_in  = "IN  ";
   logic [31:0] lab_out = "OUT ";
   localparam logic [47:0] ZERO_FIELD = "+00000";

   typedef struct {
      logic [15:0] vin;
      logic [15:0] vout;
      logic [47:0] exp_a;
      logic [47:0] exp_b;
   } vec_t;

   vec_t vecs [4];

   lcd_text_buffer #(.WIDTH(16)) dut (
      .iCLK_50MHZ (clk),
      .iRST_N     (rst_n),
      .load       (load),
      .val_in     (val_in),
      .val_out    (val_out),
      .position   (position),
      .word       (word),
      .busy       (busy),
      .done       (done)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference text for a signed value: sign then five decimal digits.
   function automatic logic [47:0] fmt_val(logic signed [15:0] v);
      int m;
      logic [47:0] s;
      m = (v < 0) ? -int'(v) : int'(v);
      s[47:40] = (v < 0) ? 8'h2D : 8'h2B;
      for (int d = 0; d < 5; d++) begin
         s[8*d +: 8] = 8'h30 + 8'(m % 10);
         m = m / 10;
      end
      return s;
   endfunction

   function automatic logic [7:0] exp_cell(int p);
      if (p < 4)              return lab_in[8*(3-p) +: 8];
      else if (p < 10)        return cur_a[8*(9-p) +: 8];
      else if (p < 16)        return 8'h20;
      else if (p < 20)        return lab_out[8*(19-p) +: 8];
      else if (p < 26)        return cur_b[8*(25-p) +: 8];
      else                    return 8'h20;
   endfunction

   task automatic check_screen(input string name);
      for (int p = 0; p < 32; p++) begin
         position = 5'(p);
         #0.2;
         check($sformatf("%s_cell%0d", name, p), {24'h0, word}, {24'h0, exp_cell(p)});
      end
   endtask

   task automatic check_field(input int base, input logic [47:0] s, input string name);
      for (int i = 0; i < 6; i++) begin
         position = 5'(base + i);
         #0.2;
         check($sformatf("%s_cell%0d", name, base + i), {24'h0, word}, {24'h0, s[8*(5-i) +: 8]});
      end
   endtask

   // Starts from an idle cycle and returns in the done cycle (after edge 34).
   task automatic run_conv(input logic [15:0] vin, input logic [15:0] vout,
                           input logic [47:0] ea, input logic [47:0] eb,
                           input int extra_k, input string name);
      logic [47:0] old_a, old_b;
      int busy_cnt, done_cnt;
      old_a = cur_a;
      old_b = cur_b;
      busy_cnt = 0;
      done_cnt = 0;
      val_in  = vin;
      val_out = vout;
      load    = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k <= 34; k++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (k == 16) check_field(4, old_a, {name, "_a_pre"});
         if (k == 17) begin
            check_field(4, ea, {name, "_a_post"});
            check_field(20, old_b, {name, "_b_hold"});
         end
         if (k == 33) check_field(20, old_b, {name, "_b_pre"});
         if (k == 34) begin
            check_field(20, eb, {name, "_b_post"});
            check_field(4, ea, {name, "_a_final"});
            check({name, "_done_at34"}, {31'h0, done}, 32'h1);
            check({name, "_busy_at34"}, {31'h0, busy}, 32'h0);
         end
         if (k < 34) begin
            load = (k == extra_k);
            if (k == extra_k) begin
               val_in  = ~vin;
               val_out = ~vout;
            end
            tick();
         end
      end
      load = 1'b0;
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd34);
      check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
      cur_a = ea;
      cur_b = eb;
   endtask

   task automatic idle_check(input string name);
      tick();
      check({name, "_done_cleared"}, {31'h0, done}, 32'h0);
      check({name, "_idle"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      vecs[0] = '{vin: 16'd42,     vout: -16'sd12345, exp_a: "+00042", exp_b: "-12345"};
      vecs[1] = '{vin: 16'h8000,   vout: 16'd32767,   exp_a: "-32768", exp_b: "+32767"};
      vecs[2] = '{vin: 16'hFFFF,   vout: 16'd0,       exp_a: "-00001", exp_b: "+00000"};
      vecs[3] = '{vin: 16'd10000,  vout: -16'sd9,     exp_a: "+10000", exp_b: "-00009"};

      rst_n    = 1'b0;
      load     = 1'b0;
      val_in   = '0;
      val_out  = '0;
      position = '0;
      cur_a    = ZERO_FIELD;
      cur_b    = ZERO_FIELD;

      #25;
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check_screen("reset");
      rst_n = 1'b1;
      tick();
      tick();

      for (int i = 0; i < 4; i++) begin
         run_conv(vecs[i].vin, vecs[i].vout, vecs[i].exp_a, vecs[i].exp_b, -1,
                  $sformatf("vec%0d", i));
         idle_check($sformatf("vec%0d", i));
         check_screen($sformatf("vec%0d_scr", i));
      end

      for (int i = 0; i < 6; i++) begin
         logic [15:0] ri, ro;
         ri = 16'($urandom);
         ro = 16'($urandom);
         run_conv(ri, ro, fmt_val(ri), fmt_val(ro), -1, $sformatf("rnd%0d", i));
         idle_check($sformatf("rnd%0d", i));
      end
      check_screen("rnd_scr");

      // A second load during conversion must be dropped.
      run_conv(16'd777, -16'sd2024, "+00777", "-02024", 10, "ignore");
      idle_check("ignore");
      repeat (3) tick();
      check("ignore_no_restart", {31'h0, busy}, 32'h0);
      check_screen("ignore_scr");

      // Reset in the middle of a conversion restores the reset image at once.
      val_in  = 16'd123;
      val_out = -16'sd456;
      load    = 1'b1;
      tick();
      load = 1'b0;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_done", {31'h0, done}, 32'h0);
      cur_a = ZERO_FIELD;
      cur_b = ZERO_FIELD;
      check_screen("midrst");
      rst_n = 1'b1;
      tick();
      run_conv(16'd31000, -16'sd7, "+31000", "-00007", -1, "after_rst");
      idle_check("after_rst");

      // Load presented in the done cycle is accepted.
      run_conv(16'd5, 16'd6, "+00005", "+00006", -1, "b2b_first");
      run_conv(-16'sd99, 16'd12345, "-00099", "+12345", -1, "b2b_second");
      idle_check("b2b");
      check_screen("b2b_scr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
